demux_route_ctrl: RTL and testbench

DEMUX_ROUTE_CTRL -- requirements
Module: demux_route_ctrl

---
 rtl/demux_route_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_demux_route_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route_ctrl.sv
// Packet demultiplexer: routes each packet to one of four channels through a
// one-entry hold register, dropping packets to disabled channels and truncating long ones.
module demux_route_ctrl #(
    parameter int MAX_BEATS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] en_mask,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [1:0] in_dest,
    input  logic       in_last,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] done,
    output logic       drop_pulse,
    output logic       trunc_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [4:0] CNT_MAX  = 5'(MAX_BEATS);
    localparam logic [4:0] CNT_LAST = 5'(MAX_BEATS - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_valid;
    logic [4:0] beat_cnt;
    logic       disabled_entry;
    logic       tail_seen;

    logic       take;
    logic       accept;
    logic       load;
    logic       decide;
    logic       cut;
    logic       drop_fin;
    logic       tail_set;

    assign take = hold_valid & out_ready[sel];
    assign accept = in_valid & in_ready;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        decide   = 1'b0;
        cut      = 1'b0;
        drop_fin = 1'b0;
        tail_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    decide  = 1'b1;
                    state_n = en_mask[in_dest] ? FWD : DROP;
                end
            end
            FWD: begin
                in_ready = ~hold_valid | out_ready[sel];
                if (in_valid && in_ready) begin
                    load = 1'b1;
                    if (in_last) begin
                        state_n = DRAIN;
                    end else if (beat_cnt == CNT_LAST) begin
                        cut     = 1'b1;
                        state_n = DROP;
                    end
                end
            end
            DRAIN: begin
                if (take && hold_last) begin
                    state_n = IDLE;
                end
            end
            DROP: begin
                in_ready = ~tail_seen;
                if (tail_seen) begin
                    if (!hold_valid) begin
                        state_n = IDLE;
                    end
                end else if (in_valid && in_last) begin
                    // A truncated tail may still sit in the hold register.
                    if (!hold_valid) begin
                        state_n  = IDLE;
                        drop_fin = disabled_entry;
                    end else begin
                        tail_set = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel            <= 2'd0;
            disabled_entry <= 1'b0;
            tail_seen      <= 1'b0;
        end else begin
            if (decide) begin
                sel            <= in_dest;
                disabled_entry <= ~en_mask[in_dest];
                tail_seen      <= 1'b0;
            end else if (tail_set) begin
                tail_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= 8'd0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (load) begin
                hold_data  <= in_data;
                hold_last  <= in_last | cut;
                hold_valid <= 1'b1;
            end else if (take) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= 5'd0;
        end else begin
            if (decide) begin
                beat_cnt <= 5'd0;
            end else if (load) begin
                if (in_last) begin
                    beat_cnt <= 5'd0;
                end else if (beat_cnt < CNT_MAX) begin
                    beat_cnt <= beat_cnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 4'd0;
            drop_pulse  <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            done        <= (take && hold_last) ? (4'b0001 << sel) : 4'd0;
            drop_pulse  <= drop_fin & accept;
            trunc_pulse <= cut;
        end
    end

    always_comb begin
        out_valid      = 4'd0;
        out_valid[sel] = hold_valid;
    end

    assign out_data = hold_data;
    assign out_last = hold_last;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scoreboard bench for demux_route_ctrl: a packet-level model predicts
// forwarded beats and pulses; a negedge monitor checks what the DUT emits.
module tb_demux_route_ctrl;

    localparam int MAXB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] dest;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en_mask = 4'hF;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic [1:0] in_dest = 2'd0;
    logic       in_last = 1'b0;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'hF;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] done;
    logic       drop_pulse;
    logic       trunc_pulse;

    int vectors = 0;
    int errors = 0;
    int rdy_mode = 1;
    int drop_exp = 0;
    int trunc_exp = 0;
    beat_t exp_q[$];
    logic [1:0] done_q[$];
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    demux_route_ctrl #(.MAX_BEATS(MAXB)) dut (
        .clk(clk),
        .rst(rst),
        .en_mask(en_mask),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_dest(in_dest),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .sel(sel),
        .busy(busy),
        .done(done),
        .drop_pulse(drop_pulse),
        .trunc_pulse(trunc_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 4'($urandom_range(0, 15));
    end

    // Monitor: every handshake and pulse is matched against the model's queues.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold_stable", out_data, prev_data);
            if (out_valid != 0 && !out_ready[sel] && !out_last)
                chk("stall_in_ready", in_ready, 0);
            if (out_valid != 0 && out_ready[sel]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_data, 0);
                    if (out_data == 0) chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_valid", out_valid, 4'b0001 << e.dest);
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                end
            end
            if (done != 0) begin
                if (done_q.size() == 0) chk("done_extra", done, 0);
                else chk("done", done, 4'b0001 << done_q.pop_front());
            end
            if (drop_pulse) begin
                chk("drop_pulse", drop_exp > 0, 1);
                if (drop_exp > 0) drop_exp--;
            end
            if (trunc_pulse) begin
                chk("trunc_pulse", trunc_exp > 0, 1);
                if (trunc_exp > 0) trunc_exp--;
            end
            prev_stall = (out_valid != 0) && !out_ready[sel];
            prev_data = out_data;
        end
    end

    task automatic wait_accept();
        logic a;
        int n = 0;
        forever begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) break;
            n++;
            if (n > 2000) begin
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 expected 1");
                $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Packet-level model: fate decided by en_mask at packet start.
    task automatic send_pkt(input logic [1:0] d, input int n,
                            input logic [3:0] m, input bit scramble);
        logic [7:0] b;
        bit on;
        int k;
        on = m[d];
        k = (n > MAXB) ? MAXB : n;
        en_mask = m;
        if (on) begin
            done_q.push_back(d);
            if (n > MAXB) trunc_exp++;
        end else begin
            drop_exp++;
        end
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            in_valid = 1'b1;
            in_data = b;
            in_dest = (i == 0) ? d : 2'($urandom);
            in_last = (i == n - 1);
            if (on && i < k) exp_q.push_back('{data: b, last: (i == k - 1), dest: d});
            wait_accept();
            if (i == 0 && scramble) en_mask = 4'($urandom);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || drop_exp != 0 ||
                trunc_exp != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_beats_left", exp_q.size(), 0);
        chk("drain_done_left", done_q.size(), 0);
        chk("drain_pulses_left", drop_exp + trunc_exp, 0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);

        send_pkt(2'd2, 3, 4'hF, 0);
        drain_all();

        fork
            send_pkt(2'd1, 8, 4'hF, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 4'b1101;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 4'hF;
            end
        join
        drain_all();

        send_pkt(2'd0, 4, 4'b1110, 0);
        drain_all();
        send_pkt(2'd3, 20, 4'hF, 0);
        drain_all();
        send_pkt(2'd3, MAXB, 4'hF, 0);
        send_pkt(2'd0, 2, 4'hF, 0);
        send_pkt(2'd3, 2, 4'hF, 0);
        drain_all();

        out_ready = 4'h0;
        en_mask = 4'hF;
        in_valid = 1'b1;
        in_dest = 2'd1;
        in_data = 8'hA5;
        in_last = 1'b0;
        wait_accept();
        in_data = 8'h5A;
        in_dest = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", out_valid, 4'b0010);
        chk("pre_rst_data", out_data, 8'hA5);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_misc", {out_last, sel, busy, done, drop_pulse, trunc_pulse, in_ready}, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 4'hF;
        send_pkt(2'd0, 3, 4'hF, 0);
        drain_all();

        rdy_mode = 0;
        for (int p = 0; p < 40; p++)
            send_pkt(2'($urandom), $urandom_range(1, 20), 4'($urandom), 1);
        rdy_mode = 1;
        out_ready = 4'hF;
        drain_all();
        finish_run();
    end

endmodule
